// File: rtl/io_turn_ctrl_pkg.sv
// Shared types for the IO turnaround controller.
// Holds the FSM state enum and the guard counter width.
package io_turn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2
    } state_t;

    localparam int CNT_W = 4;

endpackage

// File: rtl/io_turn_ctrl_if.sv
// Handshake bundle of io_turn_ctrl (tx word in, rx sample out, busy).
// master: requester side; slave: the controller.
interface io_turn_ctrl_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             rx_req;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             busy;

    modport master (
        output tx_data, tx_valid, rx_req,
        input  tx_ready, rx_data, rx_valid, busy
    );

    modport slave (
        input  tx_data, tx_valid, rx_req,
        output tx_ready, rx_data, rx_valid, busy
    );
endinterface

// File: rtl/io_turn_ctrl_sync.sv
// Two-flop synchronizer for the sampled IO bus, async reset to 0.
// Ports: clk_i, arst_ni, d_i (async in), q_o (synchronized out).
module io_turn_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             arst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;
endmodule

// File: rtl/io_turn_ctrl.sv
// Shared inout bus controller: drives tx words, inserts high-Z guard
// cycles before reads, samples IO on request.
// Ports: clk, arst_n, bus (tx/rx handshake, busy), IO (shared inout).
// Option: IO_TURN_RX_SYNC_EN adds a 2-flop synchronizer (rx latency 3).
module io_turn_ctrl
    import io_turn_pkg::*;
#(
    parameter int WIDTH       = 1,
    parameter int TURN_CYCLES = 2
) (
    input  logic          clk,
    input  logic          arst_n,
    io_turn_ctrl_if.slave bus,
    inout  wire [WIDTH-1:0] IO
);
    localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYCLES - 1);

    state_t           state_q;
    logic [WIDTH-1:0] data_q;
    logic             oe_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rx_data_q;
    logic             rx_valid_q;
    // Low until the first edge after reset; keeps tx_ready at 0 in reset.
    logic             live_q;

    logic             accept;
    logic             rx_take;
    logic [WIDTH-1:0] rx_src;

    assign bus.tx_ready = live_q &&
                          (state_q == IDLE || state_q == DRIVE);
    assign accept   = bus.tx_valid && bus.tx_ready;
    // tx has priority over rx in the same IDLE cycle.
    assign rx_take  = live_q && (state_q == IDLE) &&
                      bus.rx_req && !bus.tx_valid;

    assign IO = oe_q ? data_q : {WIDTH{1'bz}};

    assign bus.busy     = (state_q == DRIVE) || (state_q == TURN);
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            oe_q    <= 1'b0;
            cnt_q   <= '0;
            live_q  <= 1'b0;
        end else begin
            live_q <= 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        data_q  <= bus.tx_data;
                        oe_q    <= 1'b1;
                        state_q <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (accept) begin
                        data_q <= bus.tx_data;
                    end else begin
                        oe_q    <= 1'b0;
                        cnt_q   <= TURN_LOAD;
                        state_q <= TURN;
                    end
                end
                TURN: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    oe_q    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef IO_TURN_RX_SYNC_EN
    // Request tag travels alongside the synchronizer delay.
    logic [1:0] rx_pipe_q;

    io_turn_sync #(
        .WIDTH (WIDTH)
    ) u_sync (
        .clk_i   (clk),
        .arst_ni (arst_n),
        .d_i     (IO),
        .q_o     (rx_src)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rx_pipe_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            rx_pipe_q  <= {rx_pipe_q[0], rx_take};
            rx_valid_q <= rx_pipe_q[1];
            if (rx_pipe_q[1]) begin
                rx_data_q <= rx_src;
            end
        end
    end
`else
    assign rx_src = IO;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            rx_valid_q <= rx_take;
            if (rx_take) begin
                rx_data_q <= rx_src;
            end
        end
    end
`endif

endmodule

// File: tb/tb_io_turn_ctrl.sv
// Self-checking bench for io_turn_ctrl (default build).
// Main instance checked against a cycle-level behavioural model.
module tb_io_turn_ctrl;
    localparam int W  = 4;
    localparam int TC = 2;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    always #5 clk = ~clk;

    io_turn_ctrl_if #(.WIDTH(W)) bus0 ();
    io_turn_ctrl_if #(.WIDTH(1)) bus1 ();
    io_turn_ctrl_if #(.WIDTH(1)) bus2 ();

    // External agent on the main bus: drives whenever the DUT should not.
    logic         tb_en = 1'b1;
    logic [W-1:0] tb_val = '0;
    logic [W-1:0] zmask = '0;
    logic [W-1:0] zor = '0;
    wire  [W-1:0] io0;
    wire  [0:0]   io1;
    wire  [0:0]   io2;
    assign io0 = tb_en ? tb_val : {W{1'bz}};

    io_turn_ctrl #(.WIDTH(W), .TURN_CYCLES(TC)) u0 (
        .clk (clk), .arst_n (arst_n), .bus (bus0), .IO (io0));
    io_turn_ctrl #(.WIDTH(1), .TURN_CYCLES(1)) u1 (
        .clk (clk), .arst_n (arst_n), .bus (bus1), .IO (io1));
    io_turn_ctrl #(.WIDTH(1), .TURN_CYCLES(15)) u2 (
        .clk (clk), .arst_n (arst_n), .bus (bus2), .IO (io2));

    int checks = 0;
    int failures = 0;

    // Model: driving flag, remaining guard cycles, out-of-reset flag.
    bit           m_drive;
    logic [W-1:0] m_word;
    int           m_zleft;
    bit           m_live;
    logic         exp_rxv;
    logic [W-1:0] exp_rxd;

    function automatic logic exp_busy();
        return m_drive || (m_zleft > 0);
    endfunction
    function automatic logic exp_ready();
        return m_live && (m_zleft == 0);
    endfunction
    function automatic logic [W-1:0] exp_io();
        return m_drive ? m_word : tb_val;
    endfunction

    task automatic model_reset();
        m_drive = 0; m_word = '0; m_zleft = 0; m_live = 0;
        exp_rxv = 1'b0; exp_rxd = '0;
        tb_en = 1'b1; tb_val = zor;
    endtask

    task automatic tick();
        logic [W-1:0] io_pre;
        bit idle;
        @(posedge clk);
        io_pre = m_drive ? m_word : tb_val;
        idle = m_live && !m_drive && (m_zleft == 0);
        exp_rxv = idle && bus0.rx_req && !bus0.tx_valid;
        if (exp_rxv) exp_rxd = io_pre;
        if (m_zleft > 0) begin
            m_zleft--;
        end else if (bus0.tx_valid && m_live) begin
            m_drive = 1; m_word = bus0.tx_data;
        end else if (m_drive) begin
            m_drive = 0; m_zleft = TC;
        end
        m_live = 1;
        #1;
        tb_en = !m_drive;
        tb_val = (W'($urandom) & zmask) | zor;
        @(negedge clk);
    endtask

    task automatic set_in(logic v, logic [W-1:0] d, logic r);
        bus0.tx_valid = v; bus0.tx_data = d; bus0.rx_req = r;
    endtask

    task automatic test_reset();
        #12;
        checks += 5;
        if (bus0.tx_ready !== 1'b0) begin failures++;
            $display("FAIL rst_ready got=%b exp=0", bus0.tx_ready); end
        if (bus0.busy !== 1'b0) begin failures++;
            $display("FAIL rst_busy got=%b exp=0", bus0.busy); end
        if (bus0.rx_valid !== 1'b0) begin failures++;
            $display("FAIL rst_rxv got=%b exp=0", bus0.rx_valid); end
        if (bus0.rx_data !== '0) begin failures++;
            $display("FAIL rst_rxd got=%h exp=0", bus0.rx_data); end
        if (io0 !== tb_val) begin failures++;
            $display("FAIL rst_io got=%h exp=%h", io0, tb_val); end
        @(negedge clk);
        arst_n = 1'b1;
        tick();
        checks += 2;
        if (bus0.tx_ready !== 1'b1) begin failures++;
            $display("FAIL rel_ready got=%b exp=1", bus0.tx_ready); end
        if (bus0.busy !== 1'b0) begin failures++;
            $display("FAIL rel_busy got=%b exp=0", bus0.busy); end
    endtask

    task automatic test_single();
        int bcnt = 0;
        int zcnt = 0;
        zmask = '0; zor = '0;
        set_in(1'b1, W'(1), 1'b0);
        tick();
        set_in(1'b0, '0, 1'b0);
        checks++;
        if (io0 !== W'(1)) begin failures++;
            $display("FAIL single_io got=%h exp=1", io0); end
        for (int i = 0; i < 5; i++) begin
            if (bus0.busy) bcnt++;
            if (bus0.busy && !bus0.tx_ready) zcnt++;
            checks += 2;
            if (io0 !== exp_io()) begin failures++;
                $display("FAIL single_io%0d got=%h exp=%h", i, io0, exp_io()); end
            if (bus0.busy !== exp_busy()) begin failures++;
                $display("FAIL single_busy%0d got=%b exp=%b", i, bus0.busy, exp_busy()); end
            tick();
        end
        checks += 2;
        if (bcnt !== 3) begin failures++;
            $display("FAIL single_busy_len got=%0d exp=3", bcnt); end
        if (zcnt !== TC) begin failures++;
            $display("FAIL single_turn_len got=%0d exp=%0d", zcnt, TC); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] words [3];
        words[0] = W'(1); words[1] = W'(0); words[2] = W'(1);
        zmask = '0; zor = '0;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, words[i], 1'b0);
            checks++;
            if (bus0.tx_ready !== 1'b1) begin failures++;
                $display("FAIL b2b_ready%0d got=%b exp=1", i, bus0.tx_ready); end
            tick();
            checks++;
            if (io0 !== words[i]) begin failures++;
                $display("FAIL b2b_io%0d got=%h exp=%h", i, io0, words[i]); end
        end
        set_in(1'b0, '0, 1'b0);
        checks++;
        if (bus0.tx_ready !== 1'b1) begin failures++;
            $display("FAIL b2b_ready3 got=%b exp=1", bus0.tx_ready); end
        tick();
        checks += 2;
        if (bus0.tx_ready !== 1'b0 || bus0.busy !== 1'b1) begin failures++;
            $display("FAIL b2b_turn got=%b%b exp=01", bus0.tx_ready, bus0.busy); end
        if (io0 !== tb_val) begin failures++;
            $display("FAIL b2b_hiz got=%h exp=%h", io0, tb_val); end
        while (exp_busy()) tick();
    endtask

    task automatic test_rx();
        zmask = '0; zor = W'(1);
        tick();
        set_in(1'b0, '0, 1'b1);
        tick();
        set_in(1'b0, '0, 1'b0);
        checks += 2;
        if (bus0.rx_valid !== 1'b1) begin failures++;
            $display("FAIL rx_valid got=%b exp=1", bus0.rx_valid); end
        if (bus0.rx_data !== W'(1)) begin failures++;
            $display("FAIL rx_data got=%h exp=1", bus0.rx_data); end
        zor = W'(6);
        tick();
        tick();
        checks += 2;
        if (bus0.rx_valid !== 1'b0) begin failures++;
            $display("FAIL rx_pulse got=%b exp=0", bus0.rx_valid); end
        if (bus0.rx_data !== W'(1)) begin failures++;
            $display("FAIL rx_hold got=%h exp=1", bus0.rx_data); end
    endtask

    task automatic test_collision();
        zmask = '0; zor = '0;
        set_in(1'b1, W'(5), 1'b1);
        tick();
        set_in(1'b0, '0, 1'b1);
        checks += 2;
        if (bus0.rx_valid !== 1'b0) begin failures++;
            $display("FAIL coll_rxv got=%b exp=0", bus0.rx_valid); end
        if (bus0.busy !== 1'b1 || io0 !== W'(5)) begin failures++;
            $display("FAIL coll_drive got=%b/%h exp=1/5", bus0.busy, io0); end
        for (int i = 0; i < TC + 1; i++) begin
            tick();
            checks++;
            if (bus0.rx_valid !== exp_rxv) begin failures++;
                $display("FAIL turn_rxv%0d got=%b exp=%b", i, bus0.rx_valid, exp_rxv); end
        end
        set_in(1'b0, '0, 1'b0);
        tick();
    endtask

    task automatic test_reset_mid_drive();
        zmask = '0; zor = '0;
        set_in(1'b1, W'(15), 1'b0);
        tick();
        #2;
        arst_n = 1'b0;
        set_in(1'b0, '0, 1'b0);
        model_reset();
        #1;
        checks += 3;
        if (io0 !== W'(0)) begin failures++;
            $display("FAIL mid_rst_io got=%h exp=0", io0); end
        if (bus0.busy !== 1'b0) begin failures++;
            $display("FAIL mid_rst_busy got=%b exp=0", bus0.busy); end
        if (bus0.tx_ready !== 1'b0) begin failures++;
            $display("FAIL mid_rst_ready got=%b exp=0", bus0.tx_ready); end
        @(negedge clk);
        arst_n = 1'b1;
        tick();
        checks += 2;
        if (bus0.tx_ready !== 1'b1) begin failures++;
            $display("FAIL mid_rel_ready got=%b exp=1", bus0.tx_ready); end
        if (bus0.busy !== 1'b0 || io0 !== tb_val) begin failures++;
            $display("FAIL mid_rel_idle got=%b/%h exp=0/%h", bus0.busy, io0, tb_val); end
    endtask

    task automatic test_random();
        zmask = '1; zor = '0;
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 3) == 0, W'($urandom), 1'($urandom));
            tick();
            checks += 5;
            if (bus0.busy !== exp_busy()) begin failures++;
                $display("FAIL rnd_busy@%0d got=%b exp=%b", i, bus0.busy, exp_busy()); end
            if (bus0.tx_ready !== exp_ready()) begin failures++;
                $display("FAIL rnd_ready@%0d got=%b exp=%b", i, bus0.tx_ready, exp_ready()); end
            if (bus0.rx_valid !== exp_rxv) begin failures++;
                $display("FAIL rnd_rxv@%0d got=%b exp=%b", i, bus0.rx_valid, exp_rxv); end
            if (bus0.rx_data !== exp_rxd) begin failures++;
                $display("FAIL rnd_rxd@%0d got=%h exp=%h", i, bus0.rx_data, exp_rxd); end
            if (io0 !== exp_io()) begin failures++;
                $display("FAIL rnd_io@%0d got=%h exp=%h", i, io0, exp_io()); end
        end
        set_in(1'b0, '0, 1'b0);
        while (exp_busy()) tick();
    endtask

    task automatic test_turn_len();
        int n1 = 0;
        int n2 = 0;
        int guard = 0;
        bus1.tx_valid = 1'b1; bus1.tx_data = 1'b1;
        bus2.tx_valid = 1'b1; bus2.tx_data = 1'b1;
        tick();
        bus1.tx_valid = 1'b0; bus2.tx_valid = 1'b0;
        checks += 2;
        if (io1 !== 1'b1) begin failures++;
            $display("FAIL tc1_io got=%b exp=1", io1); end
        if (io2 !== 1'b1) begin failures++;
            $display("FAIL tc15_io got=%b exp=1", io2); end
        tick();
        while ((bus1.busy || bus2.busy) && guard < 40) begin
            if (bus1.busy && !bus1.tx_ready) n1++;
            if (bus2.busy && !bus2.tx_ready) n2++;
            guard++;
            tick();
        end
        checks += 3;
        if (guard >= 40) begin failures++;
            $display("FAIL turn_timeout got=%0d exp<40", guard); end
        if (n1 !== 1) begin failures++;
            $display("FAIL tc1_len got=%0d exp=1", n1); end
        if (n2 !== 15) begin failures++;
            $display("FAIL tc15_len got=%0d exp=15", n2); end
    endtask

    initial begin
        set_in(1'b0, '0, 1'b0);
        bus1.tx_valid = 1'b0; bus1.tx_data = '0; bus1.rx_req = 1'b0;
        bus2.tx_valid = 1'b0; bus2.tx_data = '0; bus2.rx_req = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_back_to_back();
        test_rx();
        test_collision();
        test_reset_mid_drive();
        test_random();
        test_turn_len();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
